inst_queue: RTL

Instruction queue between the fetch stage and decode. Accepts up to two fetched instructions per cycle from the fetch pipe register and the icache response, buffers them in a circular FIFO, and presents up to `N_ISSUE` oldest entries to decode in program order. It decouples icache bursts from decode stalls, and is cleared on exception or taken-branch redirect.

---
 rtl/inst_queue_pkg.sv | 34 +++
 rtl/inst_queue.sv | 97 +++++++++
 2 files changed

// File: rtl/inst_queue_pkg.sv
// Shared fetch-stage types and constants.
//   virt_t              : virtual address
//   address_exception_t : instruction-address exception flags
//   pipe_if_t           : fetch pipe register contents
//   inst_entry_t        : one fetched instruction as buffered by inst_queue
//   QUEUE_DEPTH         : instruction queue depth and derived pointer/count widths
package inst_queue_pkg;

  localparam int unsigned QUEUE_DEPTH = 8;
  localparam int unsigned QUEUE_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned QUEUE_CNT_W = QUEUE_PTR_W + 1;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic miss;
    logic illegal;
    logic tlb_invalid;
  } address_exception_t;

  typedef struct packed {
    logic               valid;
    virt_t              pc;
    address_exception_t iaddr_ex;
  } pipe_if_t;

  typedef struct packed {
    logic               valid;
    virt_t              pc;
    logic [31:0]        inst;
    address_exception_t iaddr_ex;
  } inst_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular FIFO of DEPTH entries; accepts up to two entries per cycle
// (valid slots compacted from tail, slot 0 oldest) and presents the
// N_ISSUE oldest entries to decode. flush empties the queue.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : exception / taken-branch redirect, clears the queue
//   push_valid    : fetch offers push_entry
//   push_entry    : two entries, slot 0 oldest, per-entry valid bit
//   push_ready    : at least two entries free
//   pop_valid     : bit i set when queue holds more than i entries
//   pop_entry     : head entries, index 0 oldest
//   pop_num       : entries consumed by decode this cycle
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH          = QUEUE_DEPTH,
  parameter int unsigned N_ISSUE        = 1,
  parameter int unsigned N_INST_CHANNEL = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               push_valid,
  input  inst_entry_t [N_INST_CHANNEL-1:0]   push_entry,
  output logic                               push_ready,
  output logic        [N_ISSUE-1:0]          pop_valid,
  output inst_entry_t [N_ISSUE-1:0]          pop_entry,
  input  logic        [$clog2(N_ISSUE+1)-1:0] pop_num
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  inst_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             fire;
  logic [CNT_W-1:0] npush;
  logic [CNT_W-1:0] pop_req;
  logic [CNT_W-1:0] npop;
  logic             wr_en0;
  logic             wr_en1;
  inst_entry_t      wr_data0;

  assign push_ready = (count <= CNT_W'(DEPTH - 2));
  assign fire       = push_valid && push_ready && !flush;

  // Compaction: the oldest valid slot always lands at tail; a second
  // write only happens when both slots are valid.
  always_comb begin
    wr_en0   = fire && (push_entry[0].valid || push_entry[1].valid);
    wr_en1   = fire && push_entry[0].valid && push_entry[1].valid;
    wr_data0 = push_entry[0].valid ? push_entry[0] : push_entry[1];
    npush    = '0;
    if (fire) begin
      npush = CNT_W'(push_entry[0].valid) + CNT_W'(push_entry[1].valid);
    end
  end

  // Over-asking pop_num is clamped so the pointers never overtake.
  always_comb begin
    pop_req = CNT_W'(pop_num);
    npop    = (pop_req > count) ? count : pop_req;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(npop);
      tail  <= tail + PTR_W'(npush);
      count <= count + npush - npop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en0) begin
      mem[tail] <= wr_data0;
    end
    if (wr_en1) begin
      mem[tail + PTR_W'(1)] <= push_entry[1];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_ISSUE; i++) begin
      pop_entry[i] = mem[head + PTR_W'(i)];
      pop_valid[i] = (count > CNT_W'(i));
    end
  end

endmodule
